// File: rtl/mem_read_arbiter.sv
// mem_read_arbiter: round-robin sharing of one DDR read-request port between
// the GP command fetch (requester 0) and the frame/pixel fetch (requester 1).
// Issue order is recorded in a small tag queue so each returning read-data
// beat can be steered back to the requester that asked for it. Return data is
// in order, so a stalled consumer at the head stalls the whole return path.
module mem_read_arbiter #(
    parameter int ADDR_W    = 31,
    parameter int BURST_LEN = 2,
    parameter int TAG_DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         req0_valid,
    input  logic [ADDR_W-1:0]            req0_addr,
    output logic                         req0_ready,
    input  logic                         req1_valid,
    input  logic [ADDR_W-1:0]            req1_addr,
    output logic                         req1_ready,
    input  logic                         af_full,
    output logic                         af_wr_en,
    output logic [ADDR_W-1:0]            af_addr_din,
    output logic [2:0]                   af_cmd_din,
    input  logic                         rdf_valid,
    input  logic [127:0]                 rdf_dout,
    output logic                         rdf_rd_en,
    output logic [127:0]                 rd_data,
    output logic                         rd0_valid,
    output logic                         rd1_valid,
    input  logic                         rd0_ready,
    input  logic                         rd1_ready,
    output logic [$clog2(TAG_DEPTH):0]   outstanding,
    output logic                         proto_err
);

    localparam int PTR_W  = $clog2(TAG_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int BEAT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

    // Registered state
    logic                 last_grant_reg;
    logic [PTR_W-1:0]     wr_ptr_reg;
    logic [PTR_W-1:0]     rd_ptr_reg;
    logic [CNT_W-1:0]     count_reg;
    logic [BEAT_W-1:0]    beat_cnt_reg;
    logic                 proto_err_reg;
    logic                 tag_mem [TAG_DEPTH];

    // Combinational decode
    logic [1:0] req_valid;
    logic [1:0] req_ready;
    logic [1:0] rd_valid;
    logic       grant;
    logic       can_issue;
    logic       push;
    logic       pop;
    logic       head;
    logic       queue_empty;
    logic       rd_en;
    logic       beat_last;

    assign req_valid   = {req1_valid, req0_valid};
    assign queue_empty = (count_reg == '0);

    // Issue is gated on the registered count, so a full queue blocks issue
    // even when a tag is being retired on the same edge.
    assign can_issue = ~rst & ~af_full & (count_reg != CNT_W'(TAG_DEPTH));

    // Lone requester wins; on a tie the one that did not win last time wins.
    assign grant = (req0_valid & req1_valid) ? ~last_grant_reg : req1_valid;

    // Tag at the read pointer names the owner of the next returning beat.
    assign head = tag_mem[rd_ptr_reg];

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_port
            assign req_ready[gi] = can_issue & (grant == 1'(gi)) & req_valid[gi];
            assign rd_valid[gi]  = ~rst & rdf_valid & ~queue_empty & (head == 1'(gi));
        end
    endgenerate

    assign push = |req_ready;

    assign rd_en     = ~rst & rdf_valid & ~queue_empty & (head ? rd1_ready : rd0_ready);
    assign beat_last = (beat_cnt_reg == BEAT_W'(BURST_LEN - 1));
    assign pop       = rd_en & beat_last;

    assign req0_ready  = req_ready[0];
    assign req1_ready  = req_ready[1];
    assign af_wr_en    = push;
    // Idle address falls back to requester 0 so the bus never floats around.
    assign af_addr_din = (push & grant) ? req1_addr : req0_addr;
    assign af_cmd_din  = 3'b001;

    assign rd_data     = rdf_dout;
    assign rd0_valid   = rd_valid[0];
    assign rd1_valid   = rd_valid[1];
    assign rdf_rd_en   = rd_en;
    assign outstanding = count_reg;
    assign proto_err   = proto_err_reg;

    // Tag storage: record the winner's ID at the write pointer on every issue.
    always_ff @(posedge clk) begin
        if (push) begin
            tag_mem[wr_ptr_reg] <= grant;
        end
    end

    // Arbiter, queue pointers, beat counter and sticky error flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant_reg <= 1'b1;
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            count_reg      <= '0;
            beat_cnt_reg   <= '0;
            proto_err_reg  <= 1'b0;
        end else begin
            if (push) begin
                last_grant_reg <= grant;
                wr_ptr_reg     <= wr_ptr_reg + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            count_reg <= count_reg + CNT_W'(push) - CNT_W'(pop);
            if (rd_en) begin
                beat_cnt_reg <= beat_last ? '0 : beat_cnt_reg + BEAT_W'(1);
            end
            if (rdf_valid & queue_empty) begin
                proto_err_reg <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mem_read_arbiter.sv
// Bench for mem_read_arbiter: directed stimulus pushes expected issues and
// returned beats into queues; a negedge monitor pops and compares whenever the
// DUT fires af_wr_en or rdf_rd_en. Static conditions are checked inline.
module tb_mem_read_arbiter;

    localparam int ADDR_W = 31;
    localparam logic [127:0] BEAT_DATA = 128'hff000000ceaa0e3ddeadbeefffffffff;

    logic               clk;
    logic               rst;
    logic               req0_valid, req1_valid;
    logic [ADDR_W-1:0]  req0_addr, req1_addr;
    logic               req0_ready, req1_ready;
    logic               af_full;
    logic               af_wr_en;
    logic [ADDR_W-1:0]  af_addr_din;
    logic [2:0]         af_cmd_din;
    logic               rdf_valid;
    logic [127:0]       rdf_dout;
    logic               rdf_rd_en;
    logic [127:0]       rd_data;
    logic               rd0_valid, rd1_valid;
    logic               rd0_ready, rd1_ready;
    logic [2:0]         outstanding;
    logic               proto_err;

    mem_read_arbiter #(
        .ADDR_W    (ADDR_W),
        .BURST_LEN (2),
        .TAG_DEPTH (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req0_valid  (req0_valid),
        .req0_addr   (req0_addr),
        .req0_ready  (req0_ready),
        .req1_valid  (req1_valid),
        .req1_addr   (req1_addr),
        .req1_ready  (req1_ready),
        .af_full     (af_full),
        .af_wr_en    (af_wr_en),
        .af_addr_din (af_addr_din),
        .af_cmd_din  (af_cmd_din),
        .rdf_valid   (rdf_valid),
        .rdf_dout    (rdf_dout),
        .rdf_rd_en   (rdf_rd_en),
        .rd_data     (rd_data),
        .rd0_valid   (rd0_valid),
        .rd1_valid   (rd1_valid),
        .rd0_ready   (rd0_ready),
        .rd1_ready   (rd1_ready),
        .outstanding (outstanding),
        .proto_err   (proto_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic              id;
        logic [ADDR_W-1:0] addr;
    } iss_t;

    typedef struct packed {
        logic         id;
        logic [127:0] data;
    } ret_t;

    iss_t iss_q[$];
    ret_t ret_q[$];
    iss_t exp_iss;
    ret_t exp_ret;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string what, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", what, act, req);
        end
    endtask

    task automatic chk1(input string what, input logic act, input logic req);
        chk(what, 128'(act), 128'(req));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rdf_valid  = 1'b0;
        rd0_ready  = 1'b0;
        rd1_ready  = 1'b0;
        af_full    = 1'b0;
    endtask

    task automatic expect_issue(input logic id, input logic [ADDR_W-1:0] addr);
        iss_q.push_back(iss_t'{id, addr});
    endtask

    task automatic beat(input logic id, input logic [127:0] d);
        rdf_valid = 1'b1;
        rdf_dout  = d;
        rd0_ready = 1'b1;
        rd1_ready = 1'b1;
        ret_q.push_back(ret_t'{id, d});
    endtask

    // Monitor: every issue and every popped beat must match the head of its queue.
    always @(negedge clk) begin
        if (af_wr_en) begin
            if (iss_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL issue_unexpected actual=%0h required=no_issue", af_addr_din);
            end else begin
                exp_iss = iss_q.pop_front();
                $display("ISSUE req%0d addr=%0h", req1_ready, af_addr_din);
                chk("issue_owner", 128'({req1_ready, req0_ready}),
                    128'(exp_iss.id ? 2'b10 : 2'b01));
                chk("issue_addr", 128'(af_addr_din), 128'(exp_iss.addr));
            end
        end
        if (rdf_rd_en) begin
            if (ret_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL beat_unexpected actual=%0h required=no_pop", rd_data);
            end else begin
                exp_ret = ret_q.pop_front();
                $display("BEAT  rd%0d data=%0h", rd1_valid, rd_data);
                chk("beat_owner", 128'({rd1_valid, rd0_valid}),
                    128'(exp_ret.id ? 2'b10 : 2'b01));
                chk("beat_data", rd_data, exp_ret.data);
            end
        end
    end

    initial begin
        rst       = 1'b1;
        req0_addr = '0;
        req1_addr = '0;
        rdf_dout  = '0;
        idle_inputs();

        // Reset held: outputs stay quiet even with activity on the inputs.
        repeat (4) @(posedge clk);
        #1;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        rdf_valid  = 1'b1;
        rd0_ready  = 1'b1;
        rd1_ready  = 1'b1;
        @(negedge clk);
        chk("rst_readies", 128'({req1_ready, req0_ready}), 128'(2'b00));
        chk1("rst_af_wr_en", af_wr_en, 1'b0);
        chk1("rst_rdf_rd_en", rdf_rd_en, 1'b0);
        chk("rst_rd_valid", 128'({rd1_valid, rd0_valid}), 128'(2'b00));
        chk("rst_outstanding", 128'(outstanding), 128'(3'd0));
        chk1("rst_proto_err", proto_err, 1'b0);
        tick();
        idle_inputs();
        rst = 1'b0;

        // Defaults after reset.
        @(negedge clk);
        chk1("dflt_af_wr_en", af_wr_en, 1'b0);
        chk1("dflt_rdf_rd_en", rdf_rd_en, 1'b0);
        chk("dflt_readies", 128'({req1_ready, req0_ready}), 128'(2'b00));
        chk("dflt_outstanding", 128'(outstanding), 128'(3'd0));
        chk1("dflt_proto_err", proto_err, 1'b0);
        chk("dflt_af_cmd", 128'(af_cmd_din), 128'(3'b001));
        tick();

        // First request from requester 0.
        req0_valid = 1'b1;
        req0_addr  = 31'h00400000;
        expect_issue(1'b0, 31'h00400000);
        @(negedge clk);
        chk1("first_req0_ready", req0_ready, 1'b1);
        chk1("first_af_wr_en", af_wr_en, 1'b1);
        tick();
        req0_valid = 1'b0;
        @(negedge clk);
        chk("first_outstanding", 128'(outstanding), 128'(3'd1));

        // Asynchronous reset with a request in flight clears the count at once.
        rst = 1'b1;
        #1;
        chk("rst1_outstanding", 128'(outstanding), 128'(3'd0));
        tick();
        rst = 1'b0;

        // Round robin: both valid for 4 cycles -> 0,1,0,1 then full.
        req0_addr = 31'h100;
        req1_addr = 31'h200;
        for (int i = 0; i < 4; i++) begin
            req0_valid = 1'b1;
            req1_valid = 1'b1;
            expect_issue(1'(i % 2), (i % 2) ? 31'h200 : 31'h100);
            tick();
        end
        @(negedge clk);
        chk("rr_full_readies", 128'({req1_ready, req0_ready}), 128'(2'b00));
        chk1("rr_full_af_wr_en", af_wr_en, 1'b0);
        chk("rr_outstanding", 128'(outstanding), 128'(3'd4));
        tick();
        idle_inputs();

        // Return steering: 8 beats, two per request, in issue order.
        for (int i = 0; i < 8; i++) begin
            beat(1'((i / 2) % 2), BEAT_DATA);
            tick();
        end
        idle_inputs();
        @(negedge clk);
        chk("steer_outstanding", 128'(outstanding), 128'(3'd0));
        tick();

        // Backpressure: head=0, consumer stalls mid-burst for 3 cycles.
        req0_valid = 1'b1;
        req0_addr  = 31'h300;
        expect_issue(1'b0, 31'h300);
        tick();
        req0_valid = 1'b0;
        beat(1'b0, BEAT_DATA ^ 128'd1);
        tick();
        rd0_ready = 1'b0;
        rdf_dout  = BEAT_DATA ^ 128'd2;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk1("bp_rdf_rd_en", rdf_rd_en, 1'b0);
            chk("bp_rd_valid", 128'({rd1_valid, rd0_valid}), 128'(2'b01));
            tick();
        end
        beat(1'b0, BEAT_DATA ^ 128'd2);
        tick();
        idle_inputs();
        @(negedge clk);
        chk("bp_beat_held", 128'(outstanding), 128'(3'd0));
        tick();

        // Address FIFO full blocks both requesters; idle address is req0_addr.
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        req0_addr  = 31'h111;
        req1_addr  = 31'h222;
        af_full    = 1'b1;
        @(negedge clk);
        chk("af_full_readies", 128'({req1_ready, req0_ready}), 128'(2'b00));
        chk1("af_full_wr_en", af_wr_en, 1'b0);
        chk("af_full_idle_addr", 128'(af_addr_din), 128'(31'h111));
        tick();
        idle_inputs();

        // Simultaneous push and last-beat pop with two outstanding.
        req0_valid = 1'b1;
        req0_addr  = 31'h500;
        expect_issue(1'b0, 31'h500);
        tick();
        req0_valid = 1'b0;
        req1_valid = 1'b1;
        req1_addr  = 31'h600;
        expect_issue(1'b1, 31'h600);
        tick();
        req1_valid = 1'b0;
        beat(1'b0, BEAT_DATA ^ 128'd3);
        tick();
        beat(1'b0, BEAT_DATA ^ 128'd4);
        req0_valid = 1'b1;
        req0_addr  = 31'h700;
        expect_issue(1'b0, 31'h700);
        @(negedge clk);
        chk("simul_fire", 128'({af_wr_en, rdf_rd_en}), 128'(2'b11));
        tick();
        idle_inputs();
        @(negedge clk);
        chk("simul_outstanding", 128'(outstanding), 128'(3'd2));
        tick();
        beat(1'b1, BEAT_DATA ^ 128'd5);
        tick();
        beat(1'b1, BEAT_DATA ^ 128'd6);
        tick();
        beat(1'b0, BEAT_DATA ^ 128'd7);
        tick();
        beat(1'b0, BEAT_DATA ^ 128'd8);
        tick();
        idle_inputs();
        @(negedge clk);
        chk("drain_outstanding", 128'(outstanding), 128'(3'd0));
        tick();

        // Beat with an empty tag queue: not popped, not steered, sticky error.
        rdf_valid = 1'b1;
        rdf_dout  = BEAT_DATA;
        rd0_ready = 1'b1;
        rd1_ready = 1'b1;
        @(negedge clk);
        chk1("perr_rdf_rd_en", rdf_rd_en, 1'b0);
        chk("perr_rd_valid", 128'({rd1_valid, rd0_valid}), 128'(2'b00));
        tick();
        idle_inputs();
        @(negedge clk);
        chk1("perr_set", proto_err, 1'b1);
        tick();
        @(negedge clk);
        chk1("perr_sticky", proto_err, 1'b1);

        // Fill the queue, then retire a tag while req0 keeps asking.
        for (int i = 0; i < 4; i++) begin
            req0_valid = 1'b1;
            req0_addr  = 31'h800 + 31'(i);
            expect_issue(1'b0, 31'h800 + 31'(i));
            tick();
        end
        beat(1'b0, BEAT_DATA ^ 128'd9);
        @(negedge clk);
        chk1("full_blk_beat0", req0_ready, 1'b0);
        tick();
        beat(1'b0, BEAT_DATA ^ 128'd10);
        @(negedge clk);
        chk1("full_blk_pop", req0_ready, 1'b0);
        tick();
        idle_inputs();
        @(negedge clk);
        chk("full_outstanding", 128'(outstanding), 128'(3'd3));
        chk1("full_perr_kept", proto_err, 1'b1);

        // Reset with 3 outstanding clears count and error immediately.
        rst = 1'b1;
        #1;
        chk("rst2_outstanding", 128'(outstanding), 128'(3'd0));
        chk1("rst2_proto_err", proto_err, 1'b0);
        tick();
        rst = 1'b0;
        tick();
        @(negedge clk);
        chk("post_outstanding", 128'(outstanding), 128'(3'd0));
        chk1("post_proto_err", proto_err, 1'b0);

        // Every expected transaction must have been seen by the monitor.
        chk("issue_queue_left", 128'(iss_q.size()), 128'(0));
        chk("beat_queue_left", 128'(ret_q.size()), 128'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
